div_sequencer: RTL and testbench

Multi-cycle divider controller for the execute stage of the pipelined MIPS core. It accepts DIV/DIVU from E, stalls the pipeline while a restoring radix-2 divider iterates one bit per cycle, and writes quotient and remainder to the HI/LO register in a single final cycle. It replaces the single-cycle divide path in the HI/LO ALU and drives the execute-stage stall that the controller and datapath already consume.

---
 rtl/div_sequencer_pkg.sv | 22 ++
 rtl/div_sequencer_if.sv | 26 ++
 rtl/div_sequencer_step.sv | 21 ++
 rtl/div_sequencer.sv | 116 +++++++++++
 tb/tb_div_sequencer.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared constants for the execute-stage divider: widths, FSM encoding,
// DIV/DIVU funct codes and the operand magnitude helper.
package div_sequencer_pkg;

  localparam int DATA_W = 32;
  localparam int DIV_CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  function automatic logic [DATA_W-1:0] mag(
    input logic              s,
    input logic [DATA_W-1:0] v
  );
    return (s & v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Execute-stage <-> divider handshake and HI/LO write bundle.
// master: execute stage, slave: div_sequencer.
interface div_sequencer_if;
  import div_sequencer_pkg::*;

  logic              start;
  logic              signed_op;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              cancel;
  logic              stall;
  logic              hilo_we;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, signed_op, opa, opb, cancel,
    input  stall, hilo_we, hi, lo
  );

  modport slave (
    input  start, signed_op, opa, opb, cancel,
    output stall, hilo_we, hi, lo
  );

endinterface

// File: rtl/div_sequencer_step.sv
// One restoring radix-2 division step, purely combinational.
module div_step
  import div_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] sh;
  logic [DATA_W:0] diff;

  // rem < dvs keeps sh below 2*dvs, so bit DATA_W of diff is the sign
  assign sh    = {rem_i, quo_i[DATA_W-1]};
  assign diff  = sh - {1'b0, dvs_i};
  assign rem_o = diff[DATA_W] ? sh[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_o = {quo_i[DATA_W-2:0], ~diff[DATA_W]};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer with pipeline stall and HI/LO write.
// Optional DIV_ZERO_FAST_EN: divide-by-zero completes in one cycle.
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  div_sequencer_if.slave  bus
);

  logic [1:0]           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]    quo_q, quo_d;
  logic [DATA_W-1:0]    dvs_q, dvs_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [DATA_W-1:0]    hi_q, hi_d;
  logic [DATA_W-1:0]    lo_q, lo_d;
  logic [DATA_W-1:0]    rem_n, quo_n;
  logic                 accept;
  logic                 last;

  div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_n),
    .quo_o (quo_n)
  );

  assign accept = (state_q == S_IDLE) & bus.start & ~bus.cancel;
  assign last   = cnt_q == DIV_CNT_W'(DATA_W - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (accept) begin
          rem_d   = '0;
          quo_d   = mag(bus.signed_op, bus.opa);
          dvs_d   = mag(bus.signed_op, bus.opb);
          qneg_d  = bus.signed_op
                  & (bus.opa[DATA_W-1] ^ bus.opb[DATA_W-1]);
          rneg_d  = bus.signed_op & bus.opa[DATA_W-1];
          cnt_d   = '0;
          state_d = S_BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (bus.opb == '0) begin
            hi_d    = bus.opa;
            lo_d    = '1;
            state_d = S_DONE;
          end
`else
`endif
        end
      end
      (state_q == S_BUSY): begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + DIV_CNT_W'(1);
        if (last) begin
          lo_d    = qneg_q ? -quo_n : quo_n;
          hi_d    = rneg_q ? -rem_n : rem_n;
          state_d = S_DONE;
        end
      end
      (state_q == S_DONE): state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
    // a flush must leave HI/LO exactly as they were
    if (bus.cancel) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.stall   = ~bus.cancel & (accept | (state_q == S_BUSY));
  assign bus.hilo_we = ~bus.cancel & (state_q == S_DONE);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a HI/LO scoreboard queue.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_sequencer_if bus();

  div_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb[$];

`ifdef DIV_ZERO_FAST_EN
  localparam int ZSTALL = 1;
`else
  localparam int ZSTALL = DATA_W + 1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input string tag, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input int est);
    int stalls;
    int cyc;
    logic [63:0] e;
    sb.push_back({ehi, elo});
    stalls = 0;
    cyc = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.signed_op = s;
    bus.opa = a;
    bus.opb = b;
    #1;
    if (bus.stall) stalls++;
    for (int c = 1; c <= DATA_W + 8 && cyc < 0; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.stall) stalls++;
      if (bus.hilo_we) cyc = c;
    end
    e = sb.pop_front();
    chk({tag, ".we_cycle"}, 32'(cyc), 32'(est));
    chk({tag, ".stall_cycles"}, 32'(stalls), 32'(est));
    chk({tag, ".lo"}, bus.lo, e[31:0]);
    chk({tag, ".hi"}, bus.hi, e[63:32]);
  endtask

  initial begin
    int we_cnt;
    bus.start = 1'b0;
    bus.signed_op = 1'b0;
    bus.opa = '0;
    bus.opb = '0;
    bus.cancel = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.stall", 32'(bus.stall), 32'd0);
    chk("reset.we", 32'(bus.hilo_we), 32'd0);
    chk("reset.hi", bus.hi, 32'd0);
    chk("reset.lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    @(negedge clk);
    #1;
    chk("hold.we", 32'(bus.hilo_we), 32'd0);
    chk("hold.lo", bus.lo, 32'd14);
    chk("hold.hi", bus.hi, 32'd2);

    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9,
            32'hFFFF_FFF2, 32'd2, 33);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 32'd0, 33);
    run_div("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'd16,
            32'h0FFF_FFFF, 32'h0000_000F, 33);

    @(negedge clk);
    bus.start = 1'b1;
    bus.signed_op = 1'b0;
    bus.opa = 32'd50;
    bus.opb = 32'd5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 10) bus.cancel = 1'b1;
    end
    #1;
    chk("cancel.stall", 32'(bus.stall), 32'd0);
    chk("cancel.we", 32'(bus.hilo_we), 32'd0);
    @(negedge clk);
    bus.cancel = 1'b0;
    #1;
    chk("cancel.after_we", 32'(bus.hilo_we), 32'd0);
    chk("cancel.after_stall", 32'(bus.stall), 32'd0);
    chk("cancel.lo", bus.lo, 32'h0FFF_FFFF);
    chk("cancel.hi", bus.hi, 32'h0000_000F);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    run_div("divu_zero", 1'b0, 32'h1234, 32'd0,
            32'hFFFF_FFFF, 32'h1234, ZSTALL);

    @(negedge clk);
    bus.start = 1'b1;
    bus.signed_op = 1'b0;
    bus.opa = 32'd100;
    bus.opb = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy.stall", 32'(bus.stall), 32'd0);
    chk("rst_busy.we", 32'(bus.hilo_we), 32'd0);
    chk("rst_busy.hi", bus.hi, 32'd0);
    chk("rst_busy.lo", bus.lo, 32'd0);
    we_cnt = 0;
    for (int c = 0; c < DATA_W + 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.hilo_we || bus.stall) we_cnt++;
    end
    chk("rst_busy.idle", 32'(we_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
